// File: rtl/boss_ctrl.sv
// -----------------------------------------------------------------------------
// boss_ctrl
//   Boss controller for the shooter game, clocked on the slow clk22 game tick.
//   Waits for every regular enemy to be gone, spawns the boss, walks it through
//   up to three HP-driven phases (each with its own waypoint on one axis),
//   issues phase-scaled fire pulses and runs a timed death sequence before
//   latching a sticky defeated flag.
//
// Ports
//   clk22     in   game tick clock
//   rst       in   synchronous active-high reset
//   gamestart in   synchronous restart, same effect as rst
//   enm_alive in   [NENM] bit i high while regular enemy i is alive
//   bosshp    in   [HPW]  current boss HP (unsigned)
//   bossx     out  [CW]   boss x position
//   bossy     out  [CW]   boss y position
//   boss      out         boss visible (active or dying)
//   phase     out  [2]    0 idle/done, 1..3 active phase
//   fire      out         single-tick fire pulse
//   dying     out         high during the death sequence
//   defeated  out         sticky, set when the death sequence completes
// -----------------------------------------------------------------------------
module boss_ctrl #(
  parameter int NENM        = 4,
  parameter int CW          = 10,
  parameter int HPW         = 10,
  parameter int HP_MAX      = 450,
  parameter int PH2_HP      = 300,
  parameter int PH3_HP      = 150,
  parameter int START_X     = 0,
  parameter int START_Y     = 75,
  parameter int WP1_X       = 220,
  parameter int WP2_Y       = 240,
  parameter int WP3_X       = 440,
  parameter int STEP        = 1,
  parameter int FIRE_PERIOD = 32,
  parameter int DEATH_CYC   = 16
) (
  input  logic            clk22,
  input  logic            rst,
  input  logic            gamestart,
  input  logic [NENM-1:0] enm_alive,
  input  logic [HPW-1:0]  bosshp,
  output logic [CW-1:0]   bossx,
  output logic [CW-1:0]   bossy,
  output logic            boss,
  output logic [1:0]      phase,
  output logic            fire,
  output logic            dying,
  output logic            defeated
);

  localparam int FCW = $clog2(FIRE_PERIOD);
  localparam int DCW = $clog2(DEATH_CYC + 1);

  localparam logic [CW-1:0]  START_X_C = CW'(START_X);
  localparam logic [CW-1:0]  START_Y_C = CW'(START_Y);
  localparam logic [CW-1:0]  WP1_X_C   = CW'(WP1_X);
  localparam logic [CW-1:0]  WP2_Y_C   = CW'(WP2_Y);
  localparam logic [CW-1:0]  WP3_X_C   = CW'(WP3_X);
  localparam logic [CW-1:0]  STEP_C    = CW'(STEP);
  localparam logic [HPW-1:0] HP_MAX_C  = HPW'(HP_MAX);
  localparam logic [HPW-1:0] PH2_C     = HPW'(PH2_HP);
  localparam logic [HPW-1:0] PH3_C     = HPW'(PH3_HP);
  localparam logic [DCW-1:0] DLAST_C   = DCW'(DEATH_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DYING  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0]  x_d, y_d;
  logic [1:0]     phase_d;
  logic           boss_d, fire_d, dying_d, defeated_d;

  logic [1:0]     tgt_phase;
  logic           mv_on_x;
  logic [CW-1:0]  mv_tgt;
  logic           arrived;

  // Phase demanded by the current HP level.
  function automatic logic [1:0] hp_phase(input logic [HPW-1:0] hp);
    if (hp > PH2_C)      return 2'd1;
    else if (hp > PH3_C) return 2'd2;
    else                 return 2'd3;
  endfunction

  // One STEP toward tgt, landing exactly on tgt when within reach.
  function automatic logic [CW-1:0] step_toward(input logic [CW-1:0] pos,
                                                input logic [CW-1:0] tgt);
    if (pos < tgt)      return ((tgt - pos) <= STEP_C) ? tgt : pos + STEP_C;
    else if (pos > tgt) return ((pos - tgt) <= STEP_C) ? tgt : pos - STEP_C;
    else                return pos;
  endfunction

  // Terminal count of the fire counter: period halves with each phase.
  function automatic logic [FCW-1:0] fire_last(input logic [1:0] ph);
    case (ph)
      2'd2:    return FCW'(FIRE_PERIOD / 2 - 1);
      2'd3:    return FCW'(FIRE_PERIOD / 4 - 1);
      default: return FCW'(FIRE_PERIOD - 1);
    endcase
  endfunction

  // Phase 2 moves y; phases 1 and 3 move x.
  always_comb begin
    tgt_phase = hp_phase(bosshp);
    mv_on_x   = (phase != 2'd2);
    case (phase)
      2'd2:    mv_tgt = WP2_Y_C;
      2'd3:    mv_tgt = WP3_X_C;
      default: mv_tgt = WP1_X_C;
    endcase
    arrived = mv_on_x ? (bossx == mv_tgt) : (bossy == mv_tgt);
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase;
    x_d        = bossx;
    y_d        = bossy;
    fcnt_d     = fcnt_q;
    dcnt_d     = dcnt_q;
    boss_d     = boss;
    fire_d     = 1'b0;
    dying_d    = dying;
    defeated_d = defeated;

    case (state_q)
      S_IDLE: begin
        if (enm_alive == '0 && bosshp != '0 && bosshp <= HP_MAX_C) begin
          state_d = S_ACTIVE;
          boss_d  = 1'b1;
          phase_d = tgt_phase;
          fcnt_d  = '0;
        end
      end

      S_ACTIVE: begin
        // Death takes priority over any phase change in the same tick.
        if (bosshp == '0) begin
          state_d = S_DYING;
          dying_d = 1'b1;
          dcnt_d  = '0;
          fcnt_d  = '0;
        end else begin
          if (mv_on_x) x_d = step_toward(bossx, mv_tgt);
          else         y_d = step_toward(bossy, mv_tgt);

          // Phase only ratchets upward; a rise in HP never demotes it.
          if (tgt_phase > phase) begin
            phase_d = tgt_phase;
            fcnt_d  = '0;
          end else if (arrived) begin
            if (fcnt_q == fire_last(phase)) begin
              fire_d = 1'b1;
              fcnt_d = '0;
            end else begin
              fcnt_d = fcnt_q + FCW'(1);
            end
          end else begin
            fcnt_d = '0;
          end
        end
      end

      S_DYING: begin
        if (dcnt_q == DLAST_C) begin
          state_d    = S_DONE;
          boss_d     = 1'b0;
          dying_d    = 1'b0;
          phase_d    = 2'd0;
          defeated_d = 1'b1;
          x_d        = START_X_C;
          y_d        = START_Y_C;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end

      S_DONE: begin
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge clk22) begin
    if (rst || gamestart) begin
      state_q  <= S_IDLE;
      phase    <= 2'd0;
      bossx    <= START_X_C;
      bossy    <= START_Y_C;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
      boss     <= 1'b0;
      fire     <= 1'b0;
      dying    <= 1'b0;
      defeated <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase    <= phase_d;
      bossx    <= x_d;
      bossy    <= y_d;
      fcnt_q   <= fcnt_d;
      dcnt_q   <= dcnt_d;
      boss     <= boss_d;
      fire     <= fire_d;
      dying    <= dying_d;
      defeated <= defeated_d;
    end
  end

endmodule

// File: tb/tb_boss_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boss_ctrl
//   Self-checking bench for boss_ctrl. Two instances share the inputs: one
//   with STEP=1 and one with STEP=3. A behavioural model tracks the expected
//   outputs of each tick by tick.
// -----------------------------------------------------------------------------
module tb_boss_ctrl;

  localparam int SX  = 0;
  localparam int SY  = 75;
  localparam int DC  = 16;
  localparam int FP  = 32;

  logic       clk22 = 1'b0;
  logic       rst, gamestart;
  logic [3:0] enm_alive;
  logic [9:0] bosshp;

  logic [9:0] bx0, by0, bx1, by1;
  logic       bs0, fr0, dy0, df0, bs1, fr1, dy1, df1;
  logic [1:0] ph0, ph1;

  int tests  = 0;
  int failed = 0;

  always #5 clk22 = ~clk22;

  boss_ctrl u_dut (
    .clk22(clk22), .rst(rst), .gamestart(gamestart), .enm_alive(enm_alive),
    .bosshp(bosshp), .bossx(bx0), .bossy(by0), .boss(bs0), .phase(ph0),
    .fire(fr0), .dying(dy0), .defeated(df0)
  );

  boss_ctrl #(.STEP(3)) u_dut3 (
    .clk22(clk22), .rst(rst), .gamestart(gamestart), .enm_alive(enm_alive),
    .bosshp(bosshp), .bossx(bx1), .bossy(by1), .boss(bs1), .phase(ph1),
    .fire(fr1), .dying(dy1), .defeated(df1)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit act;     // boss in play and fighting
    bit dy;      // death animation running
    bit done;    // boss beaten
    bit fire;
    int ph;
    int x;
    int y;
    int since;   // ticks spent arrived in the current phase since last shot
    int dt;      // ticks spent dying
  } mdl_t;

  mdl_t m[2];

  function automatic mdl_t mreset();
    mdl_t r;
    r.act = 0; r.dy = 0; r.done = 0; r.fire = 0;
    r.ph = 0; r.x = SX; r.y = SY; r.since = 0; r.dt = 0;
    return r;
  endfunction

  function automatic int want_phase(int hp);
    if (hp > 300) return 1;
    if (hp > 150) return 2;
    return 3;
  endfunction

  function automatic int approach(int pos, int tgt, int step);
    int d = tgt - pos;
    if (d > step)  d = step;
    if (d < -step) d = -step;
    return pos + d;
  endfunction

  function automatic mdl_t mstep(mdl_t s, int step, bit rs, logic [3:0] en, int hp);
    mdl_t n = s;
    n.fire = 0;
    if (rs) return mreset();
    if (s.done) return n;
    if (s.dy) begin
      n.dt = s.dt + 1;
      if (n.dt == DC) begin
        n.dy = 0; n.done = 1; n.ph = 0; n.x = SX; n.y = SY;
      end
      return n;
    end
    if (s.act) begin
      bit arr;
      int tp;
      if (hp == 0) begin
        n.act = 0; n.dy = 1; n.dt = 0;
        return n;
      end
      if (s.ph == 2) begin
        arr = (s.y == 240);
        n.y = approach(s.y, 240, step);
      end else begin
        arr = (s.x == ((s.ph == 3) ? 440 : 220));
        n.x = approach(s.x, (s.ph == 3) ? 440 : 220, step);
      end
      tp = want_phase(hp);
      if (tp > s.ph) begin
        n.ph = tp; n.since = 0;
      end else if (arr) begin
        n.since = s.since + 1;
        if (n.since == (FP >> (s.ph - 1))) begin
          n.fire = 1; n.since = 0;
        end
      end else begin
        n.since = 0;
      end
      return n;
    end
    if (en == 4'd0 && hp > 0 && hp <= 450) begin
      n.act = 1; n.ph = want_phase(hp); n.since = 0;
    end
    return n;
  endfunction

  function automatic logic [25:0] mdl_vec(int k);
    return {1'(m[k].act | m[k].dy), 2'(m[k].ph), 1'(m[k].fire), 1'(m[k].dy),
            1'(m[k].done), 10'(m[k].x), 10'(m[k].y)};
  endfunction

  function automatic logic [25:0] dut_vec(int k);
    if (k == 0) return {bs0, ph0, fr0, dy0, df0, bx0, by0};
    return {bs1, ph1, fr1, dy1, df1, bx1, by1};
  endfunction

  // One game tick: advance the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk22);
    m[0] = mstep(m[0], 1, rst | gamestart, enm_alive, int'(bosshp));
    m[1] = mstep(m[1], 3, rst | gamestart, enm_alive, int'(bosshp));
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; gamestart = 1'b0;
    enm_alive = 4'($urandom); bosshp = 10'($urandom_range(1, 450));
    tick();
    tests++;
    if ({bs0, ph0, fr0, dy0, df0, bx0, by0} !== {1'b0, 2'd0, 3'b000, 10'd0, 10'd75}) begin
      failed++;
      $display("FAIL reset_values got %h want %h", {bs0, ph0, fr0, dy0, df0, bx0, by0},
               {1'b0, 2'd0, 3'b000, 10'd0, 10'd75});
    end
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (dut_vec(k) !== mdl_vec(k)) begin
        failed++;
        $display("FAIL reset_model[%0d] got %h want %h", k, dut_vec(k), mdl_vec(k));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_wait_enemies();
    enm_alive = 4'b0010; bosshp = 10'd450;
    for (int i = 0; i < 50; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL wait_enemies[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    tests++;
    if (bs0 !== 1'b0 || bx0 !== 10'd0 || by0 !== 10'd75) begin
      failed++;
      $display("FAIL wait_no_spawn got boss=%b x=%0d y=%0d want boss=0 x=0 y=75", bs0, bx0, by0);
    end
  endtask

  task automatic test_phase1();
    int nf;
    enm_alive = 4'b0000;
    tick();
    tests++;
    if (bs0 !== 1'b1 || ph0 !== 2'd1 || bx0 !== 10'd0) begin
      failed++;
      $display("FAIL spawn_p1 got boss=%b phase=%0d x=%0d want 1 1 0", bs0, ph0, bx0);
    end
    // Enemies may reappear; the boss must ignore them now.
    for (int i = 0; i < 260; i++) begin
      enm_alive = 4'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL phase1_walk[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    tests++;
    if (bx0 !== 10'd220 || bx1 !== 10'd220) begin
      failed++;
      $display("FAIL phase1_arrive got x=%0d/%0d want 220", bx0, bx1);
    end
    nf = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      nf += int'(fr0);
    end
    tests++;
    if (nf !== 2) begin
      failed++;
      $display("FAIL phase1_fire_rate got %0d pulses want 2", nf);
    end
  endtask

  task automatic test_phase2();
    int nf;
    bosshp = 10'd200;
    tick();
    tests++;
    if (ph0 !== 2'd2 || ph1 !== 2'd2) begin
      failed++;
      $display("FAIL enter_p2 got %0d/%0d want 2", ph0, ph1);
    end
    for (int i = 0; i < 200; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL phase2_walk[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    tests++;
    if (by0 !== 10'd240 || by1 !== 10'd240 || bx0 !== 10'd220) begin
      failed++;
      $display("FAIL phase2_arrive got x=%0d y=%0d/%0d want 220 240", bx0, by0, by1);
    end
    nf = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      nf += int'(fr0);
    end
    tests++;
    if (nf !== 2) begin
      failed++;
      $display("FAIL phase2_fire_rate got %0d pulses want 2", nf);
    end
    bosshp = 10'd400;
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL phase_no_drop[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    tests++;
    if (ph0 !== 2'd2) begin
      failed++;
      $display("FAIL phase_hold got %0d want 2", ph0);
    end
  endtask

  task automatic test_phase3();
    int nf;
    bosshp = 10'd100;
    tick();
    tests++;
    if (ph0 !== 2'd3) begin
      failed++;
      $display("FAIL enter_p3 got %0d want 3", ph0);
    end
    for (int i = 0; i < 250; i++) begin
      tick();
      tests++;
      if (bx1 > 10'd440) begin
        failed++;
        $display("FAIL step3_overshoot got x=%0d want <=440", bx1);
      end
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL phase3_walk[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    tests++;
    if (bx0 !== 10'd440 || bx1 !== 10'd440) begin
      failed++;
      $display("FAIL phase3_arrive got x=%0d/%0d want 440", bx0, bx1);
    end
    nf = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      nf += int'(fr0);
    end
    tests++;
    if (nf !== 2) begin
      failed++;
      $display("FAIL phase3_fire_rate got %0d pulses want 2", nf);
    end
  endtask

  task automatic test_death();
    bosshp = 10'd0;
    tick();
    for (int i = 0; i < DC; i++) begin
      tests++;
      if (dy0 !== 1'b1 || fr0 !== 1'b0 || bs0 !== 1'b1 || bx0 !== 10'd440 || by0 !== 10'd240) begin
        failed++;
        $display("FAIL dying_frozen i=%0d got dying=%b fire=%b boss=%b x=%0d y=%0d want 1 0 1 440 240",
                 i, dy0, fr0, bs0, bx0, by0);
      end
      tick();
    end
    tests++;
    if ({bs0, ph0, dy0, df0, bx0, by0} !== {1'b0, 2'd0, 1'b0, 1'b1, 10'd0, 10'd75}) begin
      failed++;
      $display("FAIL death_done got boss=%b ph=%0d dying=%b def=%b x=%0d y=%0d want 0 0 0 1 0 75",
               bs0, ph0, dy0, df0, bx0, by0);
    end
    for (int i = 0; i < 30; i++) begin
      bosshp = 10'($urandom_range(0, 460));
      enm_alive = 4'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL done_sticky[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    tests++;
    if (df0 !== 1'b1 || bs0 !== 1'b0) begin
      failed++;
      $display("FAIL defeated_hold got def=%b boss=%b want 1 0", df0, bs0);
    end
  endtask

  task automatic test_gamestart_mid_dying();
    do_reset();
    enm_alive = 4'b0000; bosshp = 10'd120;
    for (int i = 0; i < 10; i++) tick();
    bosshp = 10'd0;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (dy0 !== 1'b1) begin
      failed++;
      $display("FAIL pre_gamestart_dying got %b want 1", dy0);
    end
    gamestart = 1'b1;
    tick();
    gamestart = 1'b0;
    tests++;
    if ({bs0, ph0, fr0, dy0, df0, bx0, by0} !== {1'b0, 2'd0, 3'b000, 10'd0, 10'd75}) begin
      failed++;
      $display("FAIL gamestart_reset got %h want %h", {bs0, ph0, fr0, dy0, df0, bx0, by0},
               {1'b0, 2'd0, 3'b000, 10'd0, 10'd75});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL after_gamestart[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    tests++;
    if (df0 !== 1'b0) begin
      failed++;
      $display("FAIL no_defeat_after_restart got %b want 0", df0);
    end
  endtask

  task automatic test_hp_range();
    do_reset();
    enm_alive = 4'b0000; bosshp = 10'd451;
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL hp_over_max[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    tests++;
    if (bs0 !== 1'b0) begin
      failed++;
      $display("FAIL hp451_no_spawn got %b want 0", bs0);
    end
    bosshp = 10'd120;
    tick();
    tests++;
    if (bs0 !== 1'b1 || ph0 !== 2'd3) begin
      failed++;
      $display("FAIL spawn_p3 got boss=%b phase=%0d want 1 3", bs0, ph0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      gamestart = ($urandom_range(0, 299) == 0);
      enm_alive = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 24) == 0)
        bosshp = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 470));
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          failed++;
          $display("FAIL random[%0d] t=%0t got %h want %h", k, $time, dut_vec(k), mdl_vec(k));
        end
      end
    end
    rst = 1'b0; gamestart = 1'b0;
  endtask

  initial begin
    rst = 1'b1; gamestart = 1'b0; enm_alive = 4'd0; bosshp = 10'd0;
    m[0] = mreset();
    m[1] = mreset();
    test_reset();
    test_wait_enemies();
    test_phase1();
    test_phase2();
    test_phase3();
    test_death();
    test_gamestart_mid_dying();
    test_hp_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/boss_ctrl.md
# boss_ctrl

Parametrised boss controller for the shooter game, clocked on the slow `clk22` game tick. It waits until every regular enemy is gone, spawns the boss, and walks it through up to three HP-driven phases, each with its own waypoint. It issues phase-scaled fire pulses and runs a timed death sequence before latching a defeated flag. It sits between the enemy/HP logic and the VGA sprite renderer and the boss-bullet generator.

## Interface
Parameters:
- `NENM`, 4, number of regular-enemy alive inputs
- `CW`, 10, coordinate width
- `HPW`, 10, HP width
- `HP_MAX`, 450, largest HP for which a spawn is allowed
- `PH2_HP`, 300, HP at or below which phase 2 starts
- `PH3_HP`, 150, HP at or below which phase 3 starts
- `START_X` / `START_Y`, 0 / 75, spawn position
- `WP1_X`, 220, phase-1 x target
- `WP2_Y`, 240, phase-2 y target
- `WP3_X`, 440, phase-3 x target
- `STEP`, 1, pixels moved per tick, ≥1
- `FIRE_PERIOD`, 32, phase-1 fire period in ticks, power of two, ≥4
- `DEATH_CYC`, 16, length of the death sequence in ticks

Ports:
- `clk22` in 1: game tick clock
- `rst` in 1: reset, synchronous, active-high
- `gamestart` in 1: synchronous restart, same effect as `rst`
- `enm_alive` in NENM: bit i = 1 while enemy i is alive
- `bosshp` in HPW: current boss HP, unsigned
- `bossx` out CW: boss x position
- `bossy` out CW: boss y position
- `boss` out 1: boss is visible (ACTIVE or DYING)
- `phase` out 2: 0 when idle or done, 1 to 3 for the active phase
- `fire` out 1: single-tick fire pulse
- `dying` out 1: high during the death sequence
- `defeated` out 1: sticky, set once the death sequence ends

## Operation
- All outputs are registered. On reset (`rst` or `gamestart`) the block enters IDLE:
  - `boss` = 0, `phase` = 0, `fire` = 0, `dying` = 0, `defeated` = 0
  - `bossx` = START_X, `bossy` = START_Y
  - fire counter = 0, death counter = 0
- States: IDLE, ACTIVE (with a `phase` sub-register), DYING, DONE.
- **IDLE to ACTIVE:** taken when `enm_alive` == 0 and 0 < `bosshp` ≤ HP_MAX. Entry phase is chosen from HP:
  - 1 if HP > PH2_HP
  - 2 if PH3_HP < HP ≤ PH2_HP
  - 3 if HP ≤ PH3_HP
  - Position stays at START.
- **Phase advance in ACTIVE:** each tick the target phase is computed from HP with the same rule. `phase` only increases, to the target; it never decreases, even if HP rises. A jump from 1 to 3 is allowed.
- **Enemies reappearing:** once ACTIVE, the boss stays ACTIVE regardless of `enm_alive`.
- **Movement:** one axis per phase; the other axis holds.
  - Phase 1: x moves toward WP1_X.
  - Phase 2: y moves toward WP2_Y.
  - Phase 3: x moves toward WP3_X.
  - Movement works in either direction by STEP per tick. It saturates exactly at the target: if |target − pos| ≤ STEP, pos = target. No overshoot and no CW wrap.
  - "Arrived" means the moving axis equals its target.
- **Fire:**
  - Period is FIRE_PERIOD >> (phase−1), i.e. 32, 16, or 8 ticks with defaults.
  - The counter runs only while ACTIVE and arrived. When it reaches period−1, `fire` = 1 for one tick and the counter returns to 0.
  - The counter clears on any phase change and while not arrived.
- **ACTIVE to DYING:** taken when `bosshp` == 0. This has priority over a phase change in the same tick.
  - Position freezes, `boss` = 1, `dying` = 1, `fire` = 0, `phase` holds.
  - The death counter counts DEATH_CYC ticks.
- **DYING to DONE:** after the DEATH_CYC-th tick in DYING.
  - `boss` = 0, `dying` = 0, `phase` = 0, `defeated` = 1.
  - Position returns to START.
  - DONE is held until reset; HP changes in DONE are ignored.
- **HP out of range in IDLE:** `bosshp` == 0 or > HP_MAX keeps the block in IDLE.

## Timing
- Spawn condition true before edge N: `boss` = 1 and `phase` is valid after edge N. The first position step is after edge N+1.
- HP crossing a threshold before edge N: `phase` updates after edge N. The new axis moves starting at edge N+1.
- Arriving at edge A: the first `fire` is high after edge A+period. Subsequent pulses come every `period` ticks.
- `bosshp` == 0 before edge D: `dying` = 1 after edge D. `dying` falls and `defeated` rises after edge D+DEATH_CYC.
- Reset asserted in any state: IDLE values appear after the next edge. This includes a reset mid-DYING, where `defeated` does not get set.
- `rst` and `gamestart` have priority over every other transition.

## Test plan
- Reset, then `enm_alive` = 4'b0010, `bosshp` = 450 for 50 ticks → `boss` stays 0, position stays (0,75). Clear `enm_alive` → `boss` = 1 and `phase` = 1 one tick later; x reaches 220 after 220 more ticks and holds; `fire` pulses every 32 ticks after arrival.
- In phase 1, set `bosshp` = 200 → `phase` = 2; y climbs 75 to 240 and stops; `fire` period becomes 16. Then set `bosshp` = 400 → `phase` stays 2.
- `bosshp` = 100 while at (220,240) → `phase` = 3; x reaches 440; `fire` every 8 ticks. With STEP = 3, check that x lands exactly on 440 with no overshoot.
- `bosshp` = 0 in phase 3 → `dying` = 1 for exactly 16 ticks, position frozen, no `fire`. Then `boss` = 0, `defeated` = 1 and stays set while `bosshp` is toggled.
- Assert `gamestart` mid-DYING → all outputs return to reset values on the next tick and `defeated` = 0.
- In IDLE, set `bosshp` = 451 with no enemies → no spawn. Then set `bosshp` = 120 → spawn directly into `phase` = 3.
